// File: rtl/muxnx2_pkg.sv
// Shared constants for the muxnx2 registered 2:1 mux.
package muxnx2_pkg;
  localparam int MUXNX2_DEFAULT_M = 16;
  localparam logic MUXNX2_RST_BIT = 1'b0;
  localparam logic [MUXNX2_DEFAULT_M-1:0] MUXNX2_RST_VAL = '0;
endpackage

// File: rtl/muxnx2_reg.sv
// M-bit output register with asynchronous active-high reset to zero; one-cycle latency.
module muxnx2_reg
  import muxnx2_pkg::*;
#(
  parameter int M = MUXNX2_DEFAULT_M
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [M-1:0] d_i,
  output logic [M-1:0] q_o
);

  logic [M-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= {M{MUXNX2_RST_BIT}};
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/muxnx2.sv
// Registered 2:1 mux: out takes I1 when sel is 1, otherwise I0, one clock later.
// No handshake; a new value is accepted every cycle.
module muxnx2
  import muxnx2_pkg::*;
#(
  parameter int M = MUXNX2_DEFAULT_M
) (
  input  logic         muxnx2_port_clk,
  input  logic         muxnx2_port_rst,
  input  logic         muxnx2_port_sel,
  input  logic [M-1:0] muxnx2_port_I0,
  input  logic [M-1:0] muxnx2_port_I1,
  output logic [M-1:0] muxnx2_port_out
);

  logic [M-1:0] out_d;

  // Only an explicit 1 picks I1; any other select value (X/Z included) falls to I0.
  always_comb begin
    out_d = muxnx2_port_I0;
    if (muxnx2_port_sel == 1'b1) begin
      out_d = muxnx2_port_I1;
    end
  end

  muxnx2_reg #(
    .M(M)
  ) u_reg (
    .clk_i(muxnx2_port_clk),
    .rst_i(muxnx2_port_rst),
    .d_i  (out_d),
    .q_o  (muxnx2_port_out)
  );

endmodule

// File: tb/tb_muxnx2.sv
// Self-checking bench for muxnx2 at M=16, with M=1 and M=32 width-corner instances.
module tb_muxnx2;

  logic        clk;
  logic        rst;
  logic        sel;
  logic [15:0] i0;
  logic [15:0] i1;
  logic [15:0] dout;

  logic        sel_1;
  logic [0:0]  i0_1;
  logic [0:0]  i1_1;
  logic [0:0]  dout_1;

  logic        sel_32;
  logic [31:0] i0_32;
  logic [31:0] i1_32;
  logic [31:0] dout_32;

  int total;
  int bad;

  muxnx2 #(.M(16)) dut (
    .muxnx2_port_clk(clk),
    .muxnx2_port_rst(rst),
    .muxnx2_port_sel(sel),
    .muxnx2_port_I0 (i0),
    .muxnx2_port_I1 (i1),
    .muxnx2_port_out(dout)
  );

  muxnx2 #(.M(1)) dut_m1 (
    .muxnx2_port_clk(clk),
    .muxnx2_port_rst(rst),
    .muxnx2_port_sel(sel_1),
    .muxnx2_port_I0 (i0_1),
    .muxnx2_port_I1 (i1_1),
    .muxnx2_port_out(dout_1)
  );

  muxnx2 #(.M(32)) dut_m32 (
    .muxnx2_port_clk(clk),
    .muxnx2_port_rst(rst),
    .muxnx2_port_sel(sel_32),
    .muxnx2_port_I0 (i0_32),
    .muxnx2_port_I1 (i1_32),
    .muxnx2_port_out(dout_32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance through one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel = 1'b1;
    i0 = 16'hFFFF;
    i1 = 16'hFFFF;
    sel_1 = 1'b1; i0_1 = 1'b1; i1_1 = 1'b1;
    sel_32 = 1'b1; i0_32 = '1; i1_32 = '1;
    #1;
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL reset_immediate: got %h want 0000", dout);
    end
    total++;
    if (dout_1 !== 1'b0 || dout_32 !== 32'h0) begin
      bad++;
      $display("FAIL reset_widths: got %h/%h want 0/00000000", dout_1, dout_32);
    end
    for (int k = 0; k < 4; k++) begin
      sel = 1'($urandom);
      i0 = 16'($urandom);
      i1 = 16'($urandom);
      tick();
      total++;
      if (dout !== 16'h0000) begin
        bad++;
        $display("FAIL reset_hold: got %h want 0000", dout);
      end
    end
  endtask

  task automatic test_sel0();
    sel = 1'b0;
    i0 = 16'h0005;
    i1 = 16'h000A;
    #2 rst = 1'b0;
    tick();
    total++;
    if (dout !== 16'h0005) begin
      bad++;
      $display("FAIL sel0_first: got %h want 0005", dout);
    end
    for (int v = 0; v < 16; v++) begin
      i1 = 16'(v);
      tick();
      total++;
      if (dout !== 16'h0005) begin
        bad++;
        $display("FAIL sel0_i1_toggle: I1=%h got %h want 0005", i1, dout);
      end
    end
  endtask

  task automatic test_sel1_sweep();
    logic [15:0] prev;
    sel = 1'b1;
    prev = dout;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        i0 = 16'(a);
        i1 = 16'(b);
        #1;
        total++;
        if (dout !== prev) begin
          bad++;
          $display("FAIL sel1_no_comb_path: got %h want %h", dout, prev);
        end
        tick();
        total++;
        if (dout !== 16'(b)) begin
          bad++;
          $display("FAIL sel1_sweep: I0=%0d I1=%0d got %h want %h", a, b, dout, 16'(b));
        end
        prev = 16'(b);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] r;
    r = 16'($urandom);
    sel = 1'b0;
    i0 = r;
    i1 = 16'h1234;
    tick();
    total++;
    if (dout !== r) begin
      bad++;
      $display("FAIL simul_pre: got %h want %h", dout, r);
    end
    sel = 1'b1;
    i1 = 16'hBEEF;
    tick();
    total++;
    if (dout !== 16'hBEEF) begin
      bad++;
      $display("FAIL simul_change: got %h want beef", dout);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] r;
    #2 rst = 1'b1;
    #1;
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_immediate: got %h want 0000", dout);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (dout !== 16'h0000) begin
      bad++;
      $display("FAIL midrst_no_reappear: got %h want 0000", dout);
    end
    r = 16'($urandom);
    sel = 1'b0;
    i0 = r;
    i1 = ~r;
    tick();
    total++;
    if (dout !== r) begin
      bad++;
      $display("FAIL midrst_first_edge: got %h want %h", dout, r);
    end
  endtask

  // Scoreboard: each cycle's chosen input is queued and must appear after the next edge.
  task automatic test_random();
    logic [15:0] expq[$];
    logic [15:0] want;
    for (int k = 0; k < 300; k++) begin
      sel = 1'($urandom);
      i0 = 16'($urandom);
      i1 = 16'($urandom);
      expq.push_back(sel ? i1 : i0);
      tick();
      want = expq.pop_front();
      total++;
      if (dout !== want) begin
        bad++;
        $display("FAIL random: cycle %0d sel=%b got %h want %h", k, sel, dout, want);
      end
    end
  endtask

  task automatic test_widths();
    logic [31:0] r;
    sel_1 = 1'b1; i0_1 = 1'b0; i1_1 = 1'b1;
    sel_32 = 1'b1; i0_32 = 32'h0; i1_32 = 32'hFFFF_FFFF;
    tick();
    total++;
    if (dout_1 !== 1'b1) begin
      bad++;
      $display("FAIL width_m1_ones: got %b want 1", dout_1);
    end
    total++;
    if (dout_32 !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL width_m32_ones: got %h want ffffffff", dout_32);
    end
    r = $urandom;
    sel_1 = 1'b0; i0_1 = 1'b0; i1_1 = 1'b1;
    sel_32 = 1'b0; i0_32 = r; i1_32 = ~r;
    tick();
    total++;
    if (dout_1 !== 1'b0 || dout_32 !== r) begin
      bad++;
      $display("FAIL width_sel0: got %b/%h want 0/%h", dout_1, dout_32, r);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_sel0();
    test_sel1_sweep();
    test_simultaneous();
    test_mid_reset();
    test_random();
    test_widths();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muxnx2.md
MUXNX2 -- requirements
Module: muxnx2

Interface
REQ-001 Parameter M: default 16; data width in bits of both inputs and the output; legal range M >= 1.
REQ-002 muxnx2_port_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 muxnx2_port_rst  input  1  reset, asynchronous, active-high.
REQ-004 muxnx2_port_sel  input  1  select: 0 picks I0, 1 picks I1.
REQ-005 muxnx2_port_I0  input  M  data input 0.
REQ-006 muxnx2_port_I1  input  M  data input 1.
REQ-007 muxnx2_port_out  output  M  registered selected data.
REQ-008 The module SHALL have exactly one clock and one reset; no other ports.

Function
REQ-009 On each rising clock edge with reset low, out SHALL load I1 when sel=1, else I0.
REQ-010 Latency SHALL be exactly one clock: a value sampled at edge n appears on out after edge n and holds until edge n+1.
REQ-011 Output SHALL be driven only by the output register; no combinational path from any input to out.
REQ-012 Selection SHALL be a full M-bit pass-through, bit-exact, with no truncation, extension or arithmetic.
REQ-013 The unselected input SHALL have no effect on out, regardless of how it toggles.
REQ-014 If sel and data change together before an edge, the values present at that edge SHALL be used.
REQ-015 sel values other than 1 (including X/Z in simulation) SHALL select I0.
REQ-016 No handshake exists: a new value SHALL be accepted every cycle, with no stall or back-pressure.

Reset
REQ-017 Asserting rst SHALL force out to all-zeros immediately, without waiting for a clock edge.
REQ-018 While rst is high, out SHALL stay zero irrespective of clock and inputs.
REQ-019 After rst deasserts, the first rising edge SHALL load the selected input per REQ-009.
REQ-020 Reset asserted mid-operation SHALL discard the held value; no prior data reappears after release.

Structure
REQ-021 Shared package muxnx2_pkg SHALL hold the default width constant (16) and the reset value constant (all-zeros).
REQ-022 A single sub-module muxnx2_reg (M-bit register with asynchronous active-high reset to zero) SHALL implement the output stage.
REQ-023 Selection logic SHALL be in muxnx2 and feed muxnx2_reg; there SHALL be no other state.

Verification (M=16 unless stated)
REQ-024 Reset check: assert rst with I0=0xFFFF, I1=0xFFFF and sel=1 -> out=0x0000 immediately, before any clock edge.
REQ-025 Select 0: sel=0, I0=0x0005, I1=0x000A, one edge -> out=0x0005; toggle I1 over 0..15 -> out remains 0x0005.
REQ-026 Select 1 with sweep: sel=1, I0 over 0..15 and I1 over 0..15 -> out equals I1 exactly one cycle later, every combination.
REQ-027 Simultaneous change: sel 0->1 and I1 0x1234->0xBEEF before the same edge -> out=0xBEEF after that edge.
REQ-028 Mid-operation reset: out=0xBEEF, pulse rst between edges -> out=0x0000 at once; first edge after release -> selected input.
REQ-029 Width corners: M=1 and M=32 builds with sel=1, I1 all-ones -> out all-ones after one edge.
